// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO decode field, register
// addresses and default FIFO depths.
package mem_io_responder_pkg;

  localparam int IO_DEC_HI = 17;
  localparam int IO_DEC_LO = 16;
  localparam logic [1:0] IO_DEC_SEL = 2'b11;

  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

  localparam int DEFAULT_TX_DEPTH = 16;
  localparam int DEFAULT_RX_DEPTH = 16;

  typedef enum logic [2:0] {
    IO_NONE,
    IO_DATA,
    IO_CTRL0,
    IO_CTRL1,
    IO_CTRL2,
    IO_CTRL3
  } io_reg_e;

  // Full 18-bit compare, so only exact register addresses inside the IO window match.
  function automatic io_reg_e decode_io(input logic [17:0] addr);
    io_reg_e reg_sel;
    case (addr)
      IO_DATA_ADDR:          reg_sel = IO_DATA;
      IO_CTRL_ADDR:          reg_sel = IO_CTRL0;
      IO_CTRL_ADDR + 18'd1:  reg_sel = IO_CTRL1;
      IO_CTRL_ADDR + 18'd2:  reg_sel = IO_CTRL2;
      IO_CTRL_ADDR + 18'd3:  reg_sel = IO_CTRL3;
      default:               reg_sel = IO_NONE;
    endcase
    return reg_sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO; a push while full is accepted only if a pop
// happens in the same cycle, so the count stays unchanged.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    store [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          pushOk, popOk;

  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);

  always_ff @(posedge clk_in) begin
    if (pushOk) begin
      store[wrPtr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_q + CW'(pushOk) - CW'(popOk);
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = store[rdPtr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM plus UART TX/RX FIFOs, program-stop flag and an
// optional cycle counter enabled by the CYCLE_COUNTER_EN macro.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = DEFAULT_TX_DEPTH,
  parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_done
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic              isIo;
  io_reg_e           ioReg;
  logic [RAM_AW-1:0] ramAddr;
  logic [7:0]        ram [0:(1 << RAM_AW) - 1];

  logic [7:0]        memDin_q, memDin_d;
  logic              ioBufFull_q;
  logic              programDone_q;

  logic              txPush, txPop, txPushOk, txFull, txEmpty;
  logic [7:0]        txHead;
  logic [TX_CW-1:0]  txCount, txCountNext;

  logic              rxPush, rxPop, rxFull, rxEmpty;
  logic [7:0]        rxHead;
  logic [RX_CW-1:0]  rxCount;

  logic              unused_ok;

  assign isIo    = (mem_a[IO_DEC_HI:IO_DEC_LO] == IO_DEC_SEL);
  assign ioReg   = isIo ? decode_io(mem_a[17:0]) : IO_NONE;
  assign ramAddr = mem_a[RAM_AW-1:0];

  always_ff @(posedge clk_in) begin
    if (!rst_in && !isIo && mem_wr) begin
      ram[ramAddr] <= mem_dout;
    end
  end

  // Zero bytes are never queued for transmit.
  assign txPush = !rst_in && mem_wr && (ioReg == IO_DATA) && (mem_dout != 8'h00);
  assign txPop  = tx_valid && tx_ready;
  assign txPushOk    = txPush && (!txFull || txPop);
  assign txCountNext = txCount + TX_CW'(txPushOk) - TX_CW'(txPop);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_txFifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (txPush),
    .wdata  (mem_dout),
    .pop    (txPop),
    .rdata  (txHead),
    .full   (txFull),
    .empty  (txEmpty),
    .count  (txCount)
  );

  assign rxPush = rx_valid && rx_ready;
  assign rxPop  = !rst_in && !mem_wr && (ioReg == IO_DATA) && !rxEmpty;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rxFifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rxPush),
    .wdata  (rx_data),
    .pop    (rxPop),
    .rdata  (rxHead),
    .full   (rxFull),
    .empty  (rxEmpty),
    .count  (rxCount)
  );

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycleCount_q;
  logic [31:0] snapshot_q;

  // Byte 0 is returned straight from the live counter, matching the snapshot taken.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycleCount_q <= '0;
      snapshot_q   <= '0;
    end else begin
      cycleCount_q <= cycleCount_q + 32'd1;
      if (!mem_wr && (ioReg == IO_CTRL0)) begin
        snapshot_q <= cycleCount_q;
      end
    end
  end
`endif

  always_comb begin
    memDin_d = 8'h00;
    if (!mem_wr) begin
      if (!isIo) begin
        memDin_d = ram[ramAddr];
      end else begin
        case (ioReg)
          IO_DATA:  memDin_d = rxEmpty ? 8'h00 : rxHead;
`ifdef CYCLE_COUNTER_EN
          IO_CTRL0: memDin_d = cycleCount_q[7:0];
          IO_CTRL1: memDin_d = snapshot_q[15:8];
          IO_CTRL2: memDin_d = snapshot_q[23:16];
          IO_CTRL3: memDin_d = snapshot_q[31:24];
`endif
          default:  memDin_d = 8'h00;
        endcase
      end
    end
  end

  // io_buffer_full tracks the post-edge TX count so it rises with the 14th byte.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      memDin_q      <= 8'h00;
      ioBufFull_q   <= 1'b0;
      programDone_q <= 1'b0;
    end else begin
      memDin_q    <= memDin_d;
      ioBufFull_q <= (txCountNext >= TX_CW'(TX_DEPTH - 2));
      if (mem_wr && (ioReg == IO_CTRL0)) begin
        programDone_q <= 1'b1;
      end
    end
  end

  assign mem_din        = memDin_q;
  assign io_buffer_full = ioBufFull_q;
  assign program_done   = programDone_q;
  assign tx_valid       = !txEmpty;
  assign tx_data        = txHead;
  assign rx_ready       = !rxFull && !rst_in;

  assign unused_ok = ^{mem_a[31:18], rxCount};

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: randomized traffic against queue
// and array reference models plus directed boundary scenarios.
module tb_mem_io_responder;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        program_done;

  int vectors     = 0;
  int miscompares = 0;
  int edgeCount   = 0;
  int lastRstEdge = 0;

  always #5 clk_in = ~clk_in;

  // Timestamp of the last edge that saw reset, used to predict counter values.
  always @(posedge clk_in) begin
    edgeCount++;
    if (rst_in) lastRstEdge = edgeCount;
  end

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .program_done   (program_done)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic setIdle();
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic resetDut();
    setIdle();
    tx_ready = 1'b0;
    rst_in   = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    resetDut();
    mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h77; tick();
    mem_a = 32'h30004; mem_dout = 8'h01; tick();
    setIdle(); rx_valid = 1'b1; rx_data = 8'h11; tick();
    setIdle(); mem_a = 32'h00100; mem_wr = 1'b1; mem_dout = 8'h5C; tick();
    setIdle(); mem_a = 32'h00100; rst_in = 1'b1; tick();
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_mem_din: got %h want 00", mem_din); end
    vectors++;
    if (io_buffer_full !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_io_full: got %b want 0", io_buffer_full); end
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tx_valid: got %b want 0", tx_valid); end
    vectors++;
    if (rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rx_ready: got %b want 0", rx_ready); end
    vectors++;
    if (program_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_prog_done: got %b want 0", program_done); end
    rst_in = 1'b0;
    mem_a  = 32'h30000;
    tick();
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_rx_empty: got %h want 00", mem_din); end
    vectors++;
    if (rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_rx_ready_after: got %b want 1", rx_ready); end
    mem_a = 32'h00100;
    tick();
    vectors++;
    if (mem_din !== 8'h5C) begin miscompares++; $display("[TB] FAIL rst_ram_kept: got %h want 5c", mem_din); end
    setIdle();
  endtask

  task automatic test_ram();
    logic [7:0]  model [int];
    logic [31:0] lastWr;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [7:0]  expected;
    bit          doRead;
    resetDut();
    mem_a = 32'h01234; mem_wr = 1'b1; mem_dout = 8'hA5; tick();
    mem_wr = 1'b0; tick();
    vectors++;
    if (mem_din !== 8'hA5) begin miscompares++; $display("[TB] FAIL ram_directed: got %h want a5", mem_din); end
    mem_a = 32'hABC01234; tick();
    vectors++;
    if (mem_din !== 8'hA5) begin miscompares++; $display("[TB] FAIL ram_alias_high_bits: got %h want a5", mem_din); end
    model[32'h01234] = 8'hA5;
    lastWr = 32'h01234;
    for (int i = 0; i < 200; i++) begin
      doRead = ($urandom_range(0, 1) == 1);
      if (doRead) begin
        if ($urandom_range(0, 1) == 1) addr = lastWr[16:0];
        else addr = 17'($urandom_range(0, 32'h1FFFF));
        if (!model.exists(int'(addr))) addr = lastWr[16:0];
        expected = model[int'(addr)];
        mem_a  = {14'($urandom), 1'b0, addr};
        mem_wr = 1'b0;
      end else begin
        addr = 17'($urandom_range(0, 32'h1FFFF));
        data = 8'($urandom);
        model[int'(addr)] = data;
        lastWr = {15'h0, addr};
        mem_a    = {14'($urandom), 1'b0, addr};
        mem_wr   = 1'b1;
        mem_dout = data;
      end
      tick();
      if (doRead) begin
        vectors++;
        if (mem_din !== expected) begin
          miscompares++;
          $display("[TB] FAIL ram_random addr %h: got %h want %h", addr, mem_din, expected);
        end
      end
    end
    setIdle();
  endtask

  task automatic test_tx_fifo();
    logic [7:0] got [$];
    resetDut();
    for (int i = 1; i <= 15; i++) begin
      mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h41;
      tick();
      vectors++;
      if (io_buffer_full !== (i >= 14)) begin
        miscompares++;
        $display("[TB] FAIL tx_full_after_write %0d: got %b want %b", i, io_buffer_full, (i >= 14));
      end
    end
    mem_dout = 8'h00; tick();
    mem_dout = 8'h41; tick();
    mem_dout = 8'h42; tick();
    vectors++;
    if (io_buffer_full !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_full_at_16: got %b want 1", io_buffer_full); end
    setIdle();
    tx_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid) got.push_back(tx_data);
      tick();
    end
    tx_ready = 1'b0;
    vectors++;
    if (got.size() !== 16) begin miscompares++; $display("[TB] FAIL tx_drain_count: got %0d want 16", got.size()); end
    foreach (got[k]) begin
      vectors++;
      if (got[k] !== 8'h41) begin miscompares++; $display("[TB] FAIL tx_drain_byte %0d: got %h want 41", k, got[k]); end
    end
    vectors++;
    if (io_buffer_full !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_full_after_drain: got %b want 0", io_buffer_full); end
  endtask

  task automatic test_tx_random();
    logic [7:0] txq [$];
    logic [7:0] data;
    bit         wr, popNow;
    resetDut();
    for (int i = 0; i < 300; i++) begin
      vectors++;
      if (tx_valid !== (txq.size() > 0)) begin
        miscompares++;
        $display("[TB] FAIL tx_rand_valid cyc %0d: got %b want %b", i, tx_valid, (txq.size() > 0));
      end
      if (txq.size() > 0) begin
        vectors++;
        if (tx_data !== txq[0]) begin
          miscompares++;
          $display("[TB] FAIL tx_rand_data cyc %0d: got %h want %h", i, tx_data, txq[0]);
        end
      end
      wr   = ($urandom_range(0, 2) != 0);
      data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tx_ready = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mem_a    = wr ? 32'h30000 : 32'h0;
      mem_wr   = wr;
      mem_dout = data;
      popNow = (txq.size() > 0) && tx_ready;
      if (wr && data != 8'h00 && (txq.size() < TX_DEPTH || popNow)) begin
        if (popNow) void'(txq.pop_front());
        txq.push_back(data);
      end else if (popNow) begin
        void'(txq.pop_front());
      end
      tick();
      vectors++;
      if (io_buffer_full !== (txq.size() >= TX_DEPTH - 2)) begin
        miscompares++;
        $display("[TB] FAIL tx_rand_full cyc %0d: got %b want %b", i, io_buffer_full, (txq.size() >= TX_DEPTH - 2));
      end
    end
    setIdle();
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] rxq [$];
    logic [7:0] expected;
    int         sizeBefore;
    bit         rd;
    resetDut();
    mem_a = 32'h30000; tick();
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL rx_empty_read: got %h want 00", mem_din); end
    setIdle();
    rx_valid = 1'b1; rx_data = 8'h5A; tick();
    rx_data = 8'h3C; tick();
    rx_valid = 1'b0; mem_a = 32'h30000; tick();
    vectors++;
    if (mem_din !== 8'h5A) begin miscompares++; $display("[TB] FAIL rx_first: got %h want 5a", mem_din); end
    tick();
    vectors++;
    if (mem_din !== 8'h3C) begin miscompares++; $display("[TB] FAIL rx_second: got %h want 3c", mem_din); end
    setIdle();
    tick();
    for (int i = 0; i < 300; i++) begin
      vectors++;
      if (rx_ready !== (rxq.size() < RX_DEPTH)) begin
        miscompares++;
        $display("[TB] FAIL rx_rand_ready cyc %0d: got %b want %b", i, rx_ready, (rxq.size() < RX_DEPTH));
      end
      rx_valid = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      rd       = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mem_a    = rd ? 32'h30000 : 32'h0;
      sizeBefore = rxq.size();
      expected = 8'h00;
      if (rd && sizeBefore > 0) expected = rxq.pop_front();
      if (rx_valid && sizeBefore < RX_DEPTH) rxq.push_back(rx_data);
      tick();
      if (rd) begin
        vectors++;
        if (mem_din !== expected) begin
          miscompares++;
          $display("[TB] FAIL rx_rand_read cyc %0d: got %h want %h", i, mem_din, expected);
        end
      end
    end
    setIdle();
  endtask

  task automatic test_counter();
    logic [31:0] snap;
    logic [31:0] later;
    logic [7:0]  expected;
    resetDut();
    repeat (1000) tick();
    snap = 32'(edgeCount - lastRstEdge);
    for (int b = 0; b < 4; b++) begin
      mem_a = 32'h30004 + 32'(b);
      tick();
`ifdef CYCLE_COUNTER_EN
      expected = snap[8*b +: 8];
`else
      expected = 8'h00;
`endif
      vectors++;
      if (mem_din !== expected) begin
        miscompares++;
        $display("[TB] FAIL counter_byte %0d: got %h want %h", b, mem_din, expected);
      end
    end
    setIdle();
    repeat (37) tick();
    mem_a = 32'h30005; tick();
`ifdef CYCLE_COUNTER_EN
    expected = snap[15:8];
`else
    expected = 8'h00;
`endif
    vectors++;
    if (mem_din !== expected) begin miscompares++; $display("[TB] FAIL counter_snapshot_held: got %h want %h", mem_din, expected); end
    later = 32'(edgeCount - lastRstEdge);
    mem_a = 32'h30004; tick();
`ifdef CYCLE_COUNTER_EN
    expected = later[7:0];
`else
    expected = 8'h00;
`endif
    vectors++;
    if (mem_din !== expected) begin miscompares++; $display("[TB] FAIL counter_resnap: got %h want %h", mem_din, expected); end
    setIdle();
  endtask

  task automatic test_other_io();
    logic [31:0] ioAddrs [6];
    logic [7:0]  ramVals [6];
    ioAddrs = '{32'h30001, 32'h30002, 32'h30003, 32'h30008, 32'h3FFFF, 32'h3000C};
    resetDut();
    for (int k = 0; k < 6; k++) begin
      ramVals[k] = 8'($urandom_range(1, 255));
      mem_a = ioAddrs[k] & 32'h1FFFF; mem_wr = 1'b1; mem_dout = ramVals[k];
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      mem_a = ioAddrs[k]; mem_wr = 1'b1; mem_dout = ~ramVals[k] | 8'h01;
      tick();
    end
    mem_wr = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL other_io_tx_untouched: got %b want 0", tx_valid); end
    vectors++;
    if (program_done !== 1'b0) begin miscompares++; $display("[TB] FAIL other_io_prog_untouched: got %b want 0", program_done); end
    for (int k = 0; k < 6; k++) begin
      mem_a = ioAddrs[k];
      tick();
      vectors++;
      if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL other_io_read %h: got %h want 00", ioAddrs[k], mem_din); end
    end
    for (int k = 0; k < 6; k++) begin
      mem_a = ioAddrs[k] & 32'h1FFFF;
      tick();
      vectors++;
      if (mem_din !== ramVals[k]) begin
        miscompares++;
        $display("[TB] FAIL other_io_ram_alias %h: got %h want %h", mem_a, mem_din, ramVals[k]);
      end
    end
    setIdle();
  endtask

  task automatic test_program_done();
    resetDut();
    mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h99; tick();
    setIdle(); rx_valid = 1'b1; rx_data = 8'h66; tick();
    setIdle();
    vectors++;
    if (program_done !== 1'b0) begin miscompares++; $display("[TB] FAIL prog_before: got %b want 0", program_done); end
    mem_a = 32'h30004; mem_wr = 1'b1; mem_dout = 8'($urandom); tick();
    setIdle();
    vectors++;
    if (program_done !== 1'b1) begin miscompares++; $display("[TB] FAIL prog_set: got %b want 1", program_done); end
    vectors++;
    if (tx_data !== 8'h99 || tx_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL prog_tx_intact: got valid %b data %h want 1 99", tx_valid, tx_data);
    end
    repeat (5) tick();
    vectors++;
    if (program_done !== 1'b1) begin miscompares++; $display("[TB] FAIL prog_sticky: got %b want 1", program_done); end
    rst_in = 1'b1; tick();
    rst_in = 1'b0;
    vectors++;
    if (program_done !== 1'b0) begin miscompares++; $display("[TB] FAIL prog_reset: got %b want 0", program_done); end
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL prog_reset_tx_empty: got %b want 0", tx_valid); end
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL prog_reset_mem_din: got %h want 00", mem_din); end
    mem_a = 32'h30000; tick();
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("[TB] FAIL prog_reset_rx_empty: got %h want 00", mem_din); end
    setIdle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_in   = 1'b1;
    tx_ready = 1'b0;
    setIdle();
    test_reset();
    test_ram();
    test_tx_fifo();
    test_tx_random();
    test_rx();
    test_counter();
    test_other_io();
    test_program_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
